stoplight_timebase: RTL and testbench
=====================================

STOPLIGHT_TIMEBASE -- requirements
Module: stoplight_timebase

Interface
REQ-001 Parameter STEP_DIV, 100000000, clk cycles per controller step tick (>=2).
REQ-002 Parameter BLINK_DIV, 25000000, clk cycles per blink half-period (>=2).
REQ-003 Parameter DEBOUNCE_CYC, 1000000, consecutive stable cycles required to accept a pedestrian button edge (>=2).
REQ-004 The module SHALL have the port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-005 The module SHALL have the port rst, input, 1, synchronous active-low reset.
REQ-006 The module SHALL have the port run, input, 1, enables step counting.
REQ-007 The module SHALL have the port btn_raw, input, 1, asynchronous pedestrian push-button, active-high.
REQ-008 The module SHALL have the port walk_ack, input, 1, the controller clears walk_req with it.
REQ-009 The module SHALL have the port step_tick, output, 1, one-cycle pulse that advances the light controller.
REQ-010 The module SHALL have the port blink, output, 1, square wave for the flashing walk lamp.
REQ-011 The module SHALL have the port walk_req, output, 1, latched pedestrian request.

Function
REQ-012 The step counter SHALL count 0..STEP_DIV-1 while run=1, wrap to 0, and hold its value while run=0.
REQ-013 step_tick SHALL be registered high for exactly one cycle on the edge where the step counter wraps; step_tick SHALL never be high for two consecutive cycles.
REQ-014 Deasserting run SHALL NOT clear the step counter; reasserting run SHALL resume from the held count.
REQ-015 The blink counter SHALL run free (independent of run), count 0..BLINK_DIV-1, and toggle blink on each wrap, giving a period of 2*BLINK_DIV cycles.
REQ-016 btn_raw SHALL pass through a 2-flop synchronizer to give btn_s; no other logic SHALL sample btn_raw.
REQ-017 The debouncer SHALL be an FSM with the states IDLE, WAIT_PRESS, PRESSED and WAIT_RELEASE.
REQ-018 In IDLE, btn_s=1 SHALL move the FSM to WAIT_PRESS with cnt=0.
REQ-019 In WAIT_PRESS, btn_s=0 SHALL return the FSM to IDLE; otherwise, cnt=DEBOUNCE_CYC-1 SHALL move it to PRESSED and any other cnt value SHALL increment cnt.
REQ-020 PRESSED SHALL last one cycle, SHALL set walk_req, and SHALL move the FSM to WAIT_RELEASE with cnt=0.
REQ-021 In WAIT_RELEASE, btn_s=1 SHALL zero cnt; otherwise, cnt=DEBOUNCE_CYC-1 SHALL return the FSM to IDLE and any other cnt value SHALL increment cnt.
REQ-022 Holding the button SHALL produce exactly one request.
REQ-023 walk_req SHALL be a sticky latch: set by a press event and cleared on the edge where walk_ack=1.
REQ-024 When a press event and walk_ack=1 occur on the same edge, walk_req SHALL remain 1 (the press wins).
REQ-025 walk_ack while walk_req=0 SHALL have no effect.
REQ-026 All counters SHALL be sized to ceil(log2(divisor)) bits, and no counter SHALL exceed its divisor-1.

Reset
REQ-027 When rst=0 at a rising edge, the module SHALL clear step_tick, blink, walk_req, all counters and both synchronizer flops, and SHALL set the FSM to IDLE.
REQ-028 Reset SHALL take priority over run, walk_ack and a pending press.
REQ-029 A reset asserted mid-debounce SHALL discard the partial count.
REQ-030 Releasing rst SHALL produce no spurious step_tick or walk_req.

Configuration
REQ-031 With macro STOPLIGHT_DEBOUNCE_EN defined, press detection SHALL use the FSM of REQ-017 to REQ-022.
REQ-032 With STOPLIGHT_DEBOUNCE_EN undefined, the FSM and debounce counter SHALL be omitted, and a press event SHALL be the rising edge of btn_s (btn_s=1 and its previous value 0).
REQ-033 Without STOPLIGHT_DEBOUNCE_EN, walk_req SHALL set on the 3rd edge after btn_raw rises.
REQ-034 With STOPLIGHT_DEBOUNCE_EN, walk_req SHALL set on the (DEBOUNCE_CYC+4)th edge after btn_raw rises, counting the first edge that samples btn_raw=1 as edge 1.

Verification
REQ-035 The bench SHALL check that, with STEP_DIV=10, rst released and run=1, step_tick pulses on the 10th, 20th and 30th edges, each pulse one cycle wide.
REQ-036 The bench SHALL check that, with STEP_DIV=10, dropping run low for 7 cycles after 4 counted cycles delays the next step_tick to 6 run-cycles after run returns high.
REQ-037 The bench SHALL check that, with BLINK_DIV=4, blink reads 0,0,0,0,1,1,1,1,0 across edges 0 to 8 after reset release.
REQ-038 The bench SHALL check that, with STOPLIGHT_DEBOUNCE_EN defined and DEBOUNCE_CYC=5, the response to btn_raw is:
  - 3-cycle glitch -> walk_req stays 0.
  - 20-cycle hold -> walk_req=1 after edge 9.
  - 20-cycle hold -> exactly one request.
  - walk_ack pulse -> walk_req=0.
REQ-039 The bench SHALL check that, with the macro undefined and DEBOUNCE_CYC=5, each rise of btn_raw sets walk_req after edge 3.
REQ-040 The bench SHALL check that a press event coinciding with walk_ack leaves walk_req=1.
REQ-041 The bench SHALL check that rst=0 mid-WAIT_PRESS followed by release with btn_raw still high restarts the full debounce and walk_req stays 0 until then.

Source files
------------

// File: rtl/stoplight_timebase.sv
// Stoplight timebase: step tick divider, free-running blink divider and latched pedestrian request (STOPLIGHT_DEBOUNCE_EN selects the FSM debouncer).
// Latency: step_tick/blink update on the counter-wrap edge; walk_req sets 3 edges after btn_raw rises, DEBOUNCE_CYC+4 edges with the debouncer.
// Backpressure: none; walk_req is held until the controller returns walk_ack.
module stoplight_timebase #(
   parameter int STEP_DIV     = 100000000,
   parameter int BLINK_DIV    = 25000000,
   parameter int DEBOUNCE_CYC = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic btn_raw,
   input  logic walk_ack,
   output logic step_tick,
   output logic blink,
   output logic walk_req
);

   localparam int STEP_W  = $clog2(STEP_DIV);
   localparam int BLINK_W = $clog2(BLINK_DIV);
   localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(STEP_DIV - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

   // Every divider needs at least two states, otherwise a tick would be high on consecutive cycles.
   if (STEP_DIV < 2 || BLINK_DIV < 2 || DEBOUNCE_CYC < 2) begin : g_bad_divisor
      $error("stoplight_timebase: STEP_DIV, BLINK_DIV and DEBOUNCE_CYC must all be >= 2");
   end

   logic [STEP_W-1:0]  step_cnt;
   logic [BLINK_W-1:0] blink_cnt;
   logic               btn_meta;
   logic               btn_s;
   logic               press;

   // Step divider: counts only while run is high and holds its value otherwise, so a pause resumes mid-period.
   always_ff @(posedge clk) begin
      if (!rst) begin
         step_cnt  <= '0;
         step_tick <= 1'b0;
      end else begin
         step_tick <= 1'b0;
         if (run) begin
            if (step_cnt == STEP_LAST) begin
               step_cnt  <= '0;
               step_tick <= 1'b1;
            end else begin
               step_cnt <= step_cnt + 1'b1;
            end
         end
      end
   end

   // Blink divider: free-running, toggles the lamp on every wrap for a 2*BLINK_DIV period.
   always_ff @(posedge clk) begin
      if (!rst) begin
         blink_cnt <= '0;
         blink     <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt <= '0;
         blink     <= ~blink;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

   // Two-flop synchronizer; btn_raw is sampled nowhere else.
   always_ff @(posedge clk) begin
      if (!rst) begin
         btn_meta <= 1'b0;
         btn_s    <= 1'b0;
      end else begin
         btn_meta <= btn_raw;
         btn_s    <= btn_meta;
      end
   end

`ifdef STOPLIGHT_DEBOUNCE_EN
   localparam int DB_W = $clog2(DEBOUNCE_CYC);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_PRESS,
      PRESSED,
      WAIT_RELEASE
   } db_state_t;

   db_state_t       db_state, db_state_nxt;
   logic [DB_W-1:0] db_cnt, db_cnt_nxt;

   // Debouncer state and stability counter; reset discards any partial count.
   always_ff @(posedge clk) begin
      if (!rst) begin
         db_state <= IDLE;
         db_cnt   <= '0;
      end else begin
         db_state <= db_state_nxt;
         db_cnt   <= db_cnt_nxt;
      end
   end

   // Press needs DEBOUNCE_CYC stable-high cycles; re-arming needs DEBOUNCE_CYC stable-low cycles, so a held button fires once.
   always_comb begin
      db_state_nxt = db_state;
      db_cnt_nxt   = db_cnt;
      press        = 1'b0;
      case (db_state)
         IDLE: begin
            if (btn_s) begin
               db_state_nxt = WAIT_PRESS;
               db_cnt_nxt   = '0;
            end
         end
         WAIT_PRESS: begin
            if (!btn_s) begin
               db_state_nxt = IDLE;
               db_cnt_nxt   = '0;
            end else if (db_cnt == DB_LAST) begin
               db_state_nxt = PRESSED;
            end else begin
               db_cnt_nxt = db_cnt + 1'b1;
            end
         end
         PRESSED: begin
            press        = 1'b1;
            db_state_nxt = WAIT_RELEASE;
            db_cnt_nxt   = '0;
         end
         WAIT_RELEASE: begin
            if (btn_s) begin
               db_cnt_nxt = '0;
            end else if (db_cnt == DB_LAST) begin
               db_state_nxt = IDLE;
               db_cnt_nxt   = '0;
            end else begin
               db_cnt_nxt = db_cnt + 1'b1;
            end
         end
         default: begin
            db_state_nxt = IDLE;
            db_cnt_nxt   = '0;
         end
      endcase
   end
`else
   logic btn_prev;

   // Previous synchronized level; a press is a clean 0->1 transition of btn_s.
   always_ff @(posedge clk) begin
      if (!rst) begin
         btn_prev <= 1'b0;
      end else begin
         btn_prev <= btn_s;
      end
   end

   assign press = btn_s & ~btn_prev;
`endif

   // Sticky request: a press outranks a simultaneous acknowledge so a fresh request is never lost.
   always_ff @(posedge clk) begin
      if (!rst) begin
         walk_req <= 1'b0;
      end else if (press) begin
         walk_req <= 1'b1;
      end else if (walk_ack) begin
         walk_req <= 1'b0;
      end
   end

endmodule

// File: tb/tb_stoplight_timebase.sv
// Bench for stoplight_timebase with small divisors: step and blink timing, run pause, button request paths.
// Each driven vector pushes its expected outputs to a scoreboard, popped and compared 1 time unit after the edge.
// Works with and without STOPLIGHT_DEBOUNCE_EN; request latency expectations follow the build.
module tb_stoplight_timebase;

   localparam int STEP_DIV     = 10;
   localparam int BLINK_DIV    = 4;
   localparam int DEBOUNCE_CYC = 5;
`ifdef STOPLIGHT_DEBOUNCE_EN
   localparam int   REQ_LAT       = DEBOUNCE_CYC + 4;
   localparam int   RST_AT        = 5;
   localparam logic GLITCH_PASSES = 1'b0;
`else
   localparam int   REQ_LAT       = 3;
   localparam int   RST_AT        = 2;
   localparam logic GLITCH_PASSES = 1'b1;
`endif

   typedef struct {
      logic       rst;
      logic       run;
      logic       btn;
      logic       ack;
      logic       tick;
      logic       blink;
      logic       req;
      logic [2:0] care;
      string      name;
   } vec_t;

   typedef struct {
      logic       tick;
      logic       blink;
      logic       req;
      logic [2:0] care;
      string      name;
   } exp_t;

   logic clk = 1'b0;
   logic rst, run, btn_raw, walk_ack;
   logic step_tick, blink, walk_req;

   exp_t sb_q[$];
   vec_t tbl[$];
   int   n_checks = 0;
   int   n_errors = 0;

   stoplight_timebase #(
      .STEP_DIV    (STEP_DIV),
      .BLINK_DIV   (BLINK_DIV),
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .btn_raw  (btn_raw),
      .walk_ack (walk_ack),
      .step_tick(step_tick),
      .blink    (blink),
      .walk_req (walk_req)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic ru, input logic b, input logic a,
                               input logic t, input logic bl, input logic rq,
                               input logic [2:0] care, input string nm);
      vec_t v;
      v.rst = r;  v.run = ru; v.btn = b;   v.ack = a;
      v.tick = t; v.blink = bl; v.req = rq;
      v.care = care; v.name = nm;
      return v;
   endfunction

   task automatic check_next();
      exp_t       e;
      logic [2:0] act;
      logic [2:0] want;
      if (sb_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL scoreboard_empty: output seen with no expected entry");
         return;
      end
      e    = sb_q.pop_front();
      act  = {step_tick, blink, walk_req};
      want = {e.tick, e.blink, e.req};
      if (e.care != 3'b000) begin
         n_checks++;
         if (((act ^ want) & e.care) != 3'b000) begin
            n_errors++;
            $display("FAIL %s: got tick,blink,req=%b required %b (mask %b) at %0t",
                     e.name, act, want, e.care, $time);
         end
      end
   endtask

   task automatic apply(input vec_t v);
      exp_t e;
      rst      = v.rst;
      run      = v.run;
      btn_raw  = v.btn;
      walk_ack = v.ack;
      e.tick = v.tick; e.blink = v.blink; e.req = v.req;
      e.care = v.care; e.name = v.name;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      check_next();
   endtask

   // Button-phase cycle with run low: step_tick must stay quiet and only walk_req is checked.
   task automatic bcyc(input logic b, input logic a, input logic rq, input string nm);
      apply(mk(1'b1, 1'b0, b, a, 1'b0, 1'b0, rq, 3'b101, nm));
   endtask

   task automatic do_reset(input string nm);
      for (int i = 0; i < 2; i++) apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111, nm));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic blink_seq [1:8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      rst = 1'b0; run = 1'b0; btn_raw = 1'b0; walk_ack = 1'b0;

      // Reset wins over run and walk_ack; then blink 0,0,0,1,1,1,1,0 over edges 1..8 with no tick.
      for (int i = 0; i < 3; i++)
         tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b111, "reset_state"));
      for (int k = 1; k <= 8; k++)
         tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, blink_seq[k], 1'b0, 3'b111, "blink_after_release"));
      foreach (tbl[i]) apply(tbl[i]);

      // Continuous run: ticks on edges 10, 20, 30 only; blink keeps its 8-cycle period.
      for (int k = 9; k <= 30; k++)
         apply(mk(1'b1, 1'b1, 1'b0, 1'b0, (k % 10) == 0, ((k / 4) % 2) == 1, 1'b0, 3'b111, "step_period"));

      // Pause after 4 counted cycles for 7 cycles; the tick lands 6 run-cycles after resuming.
      for (int k = 1; k <= 4; k++) apply(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, "run_before_pause"));
      for (int k = 1; k <= 7; k++) apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, "run_paused"));
      for (int k = 1; k <= 7; k++)
         apply(mk(1'b1, 1'b1, 1'b0, 1'b0, k == 6, 1'b0, 1'b0, 3'b100, "run_resumed"));

      do_reset("reset_before_button");

      // Long hold: one request at REQ_LAT, cleared by ack, never re-raised while held or on release.
      for (int k = 1; k <= 20; k++)
         bcyc(1'b1, k == 13, (k >= REQ_LAT) && (k < 13), "hold_press");
      for (int k = 1; k <= 12; k++) bcyc(1'b0, 1'b0, 1'b0, "hold_release");

      // Three-cycle glitch: rejected by the debouncer, an edge press without it.
      for (int k = 1; k <= 3; k++) bcyc(1'b1, 1'b0, GLITCH_PASSES && (k >= 3), "glitch");
      for (int k = 1; k <= 12; k++) bcyc(1'b0, 1'b0, GLITCH_PASSES, "glitch_after");
      bcyc(1'b0, 1'b1, 1'b0, "glitch_ack_clear");
      bcyc(1'b0, 1'b0, 1'b0, "idle_after_ack");

      // Ack held while idle has no effect; the press landing with ack still sets the request.
      for (int k = 1; k <= REQ_LAT; k++) bcyc(1'b1, 1'b1, k == REQ_LAT, "press_with_ack");
      for (int k = 1; k <= 3; k++) bcyc(1'b1, 1'b0, 1'b1, "press_wins_hold");
      for (int k = 1; k <= 12; k++) bcyc(1'b0, 1'b0, 1'b1, "req_sticky");
      bcyc(1'b0, 1'b1, 1'b0, "ack_clears");
      bcyc(1'b0, 1'b0, 1'b0, "ack_idle");

      // Reset in the middle of a press with the button still held restarts the full latency.
      for (int k = 1; k <= RST_AT; k++) bcyc(1'b1, 1'b0, 1'b0, "press_before_reset");
      apply(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111, "reset_mid_press"));
      for (int k = 1; k <= REQ_LAT + 2; k++) bcyc(1'b1, 1'b0, k >= REQ_LAT, "press_after_reset");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
